// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
// Optional phase-realign port is enabled with CLKDIV_SYNC_EN.
package clk_div_pkg;

  localparam int unsigned MAX_CNT_W  = 32;
  localparam int unsigned DEF_NUM_CH = 2;
  localparam int unsigned DEF_CNT_W  = 18;
  localparam int unsigned DEF_DIV    = 100000;

  typedef logic [MAX_CNT_W-1:0] cnt_t;

  localparam cnt_t MIN_DIV = cnt_t'(2);

  typedef struct packed {
    cnt_t cnt;
    cnt_t div;
    cnt_t pdiv;
    logic pend;
  } ch_state_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, active and pending divisor.
// Port sync exists only when CLKDIV_SYNC_EN is defined.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic             acc,
  input  logic [CNT_W-1:0] acc_div,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  localparam cnt_t RST_DIV = cnt_t'(DEFAULT_DIV);

  ch_state_t st_q, st_d;
  logic      clk_out_q, clk_out_d;
  logic      tick_q, tick_d;
  cnt_t      hi_m1, nxt, ld;
  logic      restart, wrap;

  always_comb begin
    hi_m1 = ((st_q.div + cnt_t'(1)) >> 1) - cnt_t'(1);
    nxt   = cnt_t'(st_q.cnt[CNT_W-1:0] + CNT_W'(1));
    wrap  = (st_q.cnt == st_q.div - cnt_t'(1));
    ld    = cnt_t'(acc_div);
    if (ld < MIN_DIV) ld = MIN_DIV;
`ifdef CLKDIV_SYNC_EN
    restart = !en || sync;
`else
    restart = !en;
`endif

    st_d      = st_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;

    // Divisor only ever switches at a period boundary, so no glitch.
    if (restart || wrap) begin
      st_d.cnt  = '0;
      clk_out_d = 1'b1;
      tick_d    = !restart;
      if (st_q.pend) begin
        st_d.div  = st_q.pdiv;
        st_d.pend = 1'b0;
      end
    end else begin
      st_d.cnt = nxt;
      if (st_q.cnt == hi_m1) clk_out_d = 1'b0;
    end

    if (acc) begin
      st_d.pdiv = ld;
      st_d.pend = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q.cnt  <= '0;
      st_q.div  <= RST_DIV;
      st_q.pdiv <= RST_DIV;
      st_q.pend <= 1'b0;
      clk_out_q <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pend    = st_q.pend;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent clock dividers with a shared divisor-load port.
// Define CLKDIV_SYNC_EN to add the sync phase-realign input.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DEF_DIV,
  localparam int unsigned LCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync,
`endif
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              load_valid,
  input  logic [LCH_W-1:0]  load_ch,
  input  logic [CNT_W-1:0]  load_div,
  output logic              load_ready,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] acc;

  // Out-of-range channel index: ready, but nothing is accepted.
  always_comb begin
    load_ready = 1'b1;
    acc        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(load_ch) == 32'(i)) begin
        load_ready = !pend[i];
        acc[i]     = load_valid && !pend[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (ch_en[g]),
`ifdef CLKDIV_SYNC_EN
      .sync    (sync),
`endif
      .acc     (acc[g]),
      .acc_div (load_div),
      .pend    (pend[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed + randomized bench for clk_div_multi against a timestamp model.
// Exercises the sync strobe when built with CLKDIV_SYNC_EN.
module tb_clk_div_multi;

  localparam int NCH = 3;

`ifdef CLKDIV_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n;
  logic [NCH-1:0] ch_en;
  logic           load_valid;
  logic [1:0]     load_ch;
  logic [7:0]     load_div;
  logic           load_ready;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
  logic           sync_i;
`endif

  int ncmp  = 0;
  int nfail = 0;

  // Model: each period is a timestamp t0 and a length P.
  int c;
  int t0 [NCH];
  int P  [NCH];
  int pp [NCH];
  bit pm [NCH];
  bit wr [NCH];

  clk_div_multi #(
    .NUM_CH      (NCH),
    .CNT_W       (8),
    .DEFAULT_DIV (10)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef CLKDIV_SYNC_EN
    .sync       (sync_i),
`endif
    .ch_en      (ch_en),
    .load_valid (load_valid),
    .load_ch    (load_ch),
    .load_div   (load_div),
    .load_ready (load_ready),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    c = 0;
    for (int i = 0; i < NCH; i++) begin
      t0[i] = 0; P[i] = 10; pp[i] = 10; pm[i] = 0; wr[i] = 0;
    end
  endtask

  task automatic step(input logic [NCH-1:0] e, input bit lv,
                      input logic [1:0] lch, input logic [7:0] ld,
                      input bit s);
    bit             rdy;
    bit             rs;
    logic [NCH-1:0] ec, et;
    ch_en = e; load_valid = lv; load_ch = lch; load_div = ld;
`ifdef CLKDIV_SYNC_EN
    sync_i = s;
`endif
    #1;
    rdy = (lch < NCH) ? !pm[lch] : 1'b1;
    chk("load_ready", 32'(load_ready), 32'(rdy));
    @(posedge clk);
    c++;
    for (int i = 0; i < NCH; i++) begin
      rs = !e[i] || (SYNC_ON && s);
      wr[i] = 0;
      if (rs || (c - t0[i] == P[i])) begin
        wr[i] = !rs;
        t0[i] = c;
        if (pm[i]) begin P[i] = pp[i]; pm[i] = 0; end
      end
      if (lv && rdy && int'(lch) == i) begin
        pp[i] = (ld < 2) ? 2 : int'(ld);
        pm[i] = 1;
      end
    end
    #1;
    for (int i = 0; i < NCH; i++) begin
      ec[i] = (c - t0[i]) < (P[i] + 1) / 2;
      et[i] = wr[i];
    end
    chk("clk_out", 32'(clk_out), 32'(ec));
    chk("tick", 32'(tick), 32'(et));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('1, 0, 0, 0, 0);
  endtask

  initial begin
    int guard;
    logic [NCH-1:0] re;
    logic [7:0]     rd;
    reset_n = 1'b0; ch_en = '1; load_valid = 0; load_ch = 0; load_div = 0;
`ifdef CLKDIV_SYNC_EN
    sync_i = 0;
`endif
    reset_model();
    repeat (3) @(negedge clk);
    chk("rst_clk_out", 32'(clk_out), 32'h7);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h1);
    reset_n = 1'b1;

    // Default divisor 10: 5 high / 5 low, tick every 10.
    idle(25);

    // Odd divisor on ch0, then a second load held off while pending.
    step('1, 1, 0, 8'd7, 0);
    guard = 0;
    while (pm[0] && guard < 40) begin
      step('1, 1, 0, 8'd3, 0);
      guard++;
    end
    chk("pend_wait", 32'(guard < 40), 32'h1);
    idle(30);

    // Clamp of 0 and 1, and an out-of-range channel index.
    step('1, 1, 1, 8'd0, 0);
    step('1, 1, 2, 8'd1, 0);
    step('1, 1, 3, 8'd5, 0);
    idle(30);

    // Drop ch0 enable at count 3, then re-enable.
    guard = 0;
    while ((c - t0[0]) != 3 && guard < 40) begin
      step('1, 0, 0, 0, 0);
      guard++;
    end
    chk("reach_cnt3", 32'(c - t0[0]), 32'd3);
    step(3'b110, 0, 0, 0, 0);
    step(3'b110, 0, 0, 0, 0);
    idle(20);

    // Reload ch0 to 10 and ch1 to 4, then realign phase.
    step('1, 1, 0, 8'd10, 0);
    step('1, 1, 1, 8'd4, 0);
    idle(27);
    step('1, 0, 0, 0, 1);
    idle(12);

    // Asynchronous reset mid-period with an update pending.
    step('1, 1, 2, 8'd9, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_clk_out", 32'(clk_out), 32'h7);
    chk("arst_tick", 32'(tick), 32'h0);
    chk("arst_ready", 32'(load_ready), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    reset_model();
    idle(22);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < NCH; i++) re[i] = ($urandom_range(0, 30) != 0);
      case ($urandom_range(0, 5))
        0:       rd = 8'd0;
        1:       rd = 8'd1;
        default: rd = 8'($urandom_range(2, 16));
      endcase
      step(re, $urandom_range(0, 6) == 0, 2'($urandom_range(0, 3)), rd,
           $urandom_range(0, 60) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
